dmem_responder: RTL

- Data-memory responder for the RV32IM core.
- Sits on the memory side of the M-stage access path. It accepts load/store requests over a valid/ready handshake and owns a word-organised single-port array.
- Sub-word stores (SB/SH) are done by read-modify-write. Misaligned and out-of-range accesses are flagged.
- Load data is returned as the full aligned word; sign/zero extension stays in write-back.

---
 rtl/dmem_responder_if.sv | 25 ++
 rtl/dmem_responder.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/dmem_responder_if.sv
// Request/response bus between the M-stage access path and the data-memory responder.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  // Core side: issues requests, consumes responses.
  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  // Memory side: accepts requests, produces responses.
  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised single-port array behind a valid/ready
// request/response handshake. Sub-word stores use read-modify-write; loads return
// the full aligned word and leave extension to write-back.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input logic             CLK,
  input logic             RST,
  dmem_responder_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state;
  state_t nextState;

  logic [IDX_W-1:0] idxQ;
  logic [1:0]       offQ;
  logic [1:0]       sizeQ;
  logic             weQ;
  logic [31:0]      wdataQ;
  logic [31:0]      mergeQ;
  logic [31:0]      rdataQ;
  logic             errQ;
  logic             validQ;
  logic             readyQ;

  logic [31:0]      mem [DEPTH_WORDS];

  logic             acceptC;
  logic             errC;
  logic [31:0]      wrWordC;

  assign acceptC       = bus.req_valid & readyQ;
  assign bus.req_ready = readyQ;
  assign bus.rsp_valid = validQ;
  assign bus.rsp_rdata = rdataQ;
  assign bus.rsp_err   = errQ;

  // Classify the incoming request: illegal size, misalignment, or beyond the array.
  always_comb begin
    errC = 1'b0;
    case (bus.req_size)
      SZ_HALF: errC = bus.req_addr[0];
      SZ_WORD: errC = |bus.req_addr[1:0];
      SZ_BAD:  errC = 1'b1;
      default: errC = 1'b0;
    endcase
    if (bus.req_addr[31:2] >= 30'(DEPTH_WORDS)) begin
      errC = 1'b1;
    end
  end

  // Word to write: full store data, or the old word with the selected lanes replaced.
  always_comb begin
    wrWordC = mergeQ;
    case (sizeQ)
      SZ_HALF: begin
        if (offQ[1]) wrWordC[31:16] = wdataQ[15:0];
        else         wrWordC[15:0]  = wdataQ[15:0];
      end
      SZ_BYTE: begin
        case (offQ)
          2'd0:    wrWordC[7:0]   = wdataQ[7:0];
          2'd1:    wrWordC[15:8]  = wdataQ[7:0];
          2'd2:    wrWordC[23:16] = wdataQ[7:0];
          default: wrWordC[31:24] = wdataQ[7:0];
        endcase
      end
      default: wrWordC = wdataQ;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= nextState;
  end

  // Next-state: errors skip the array; sub-word stores read before writing.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (acceptC) begin
          if (errC)                         nextState = RESP;
          else if (!bus.req_we)             nextState = RD;
          else if (bus.req_size == SZ_WORD) nextState = WR;
          else                              nextState = RD;
        end
      end
      RD:      nextState = weQ ? WR : RESP;
      WR:      nextState = RESP;
      RESP:    nextState = bus.rsp_ready ? IDLE : RESP;
      default: nextState = IDLE;
    endcase
  end

  // Request latches, merge buffer and registered response outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idxQ   <= '0;
      offQ   <= 2'b00;
      sizeQ  <= 2'b00;
      weQ    <= 1'b0;
      wdataQ <= 32'h0;
      mergeQ <= 32'h0;
      rdataQ <= 32'h0;
      errQ   <= 1'b0;
      validQ <= 1'b0;
      readyQ <= 1'b1;
    end else begin
      if (acceptC) begin
        idxQ   <= bus.req_addr[IDX_W+1:2];
        offQ   <= bus.req_addr[1:0];
        sizeQ  <= bus.req_size;
        weQ    <= bus.req_we;
        wdataQ <= bus.req_wdata;
        errQ   <= errC;
        rdataQ <= 32'h0;
      end
      if (state == RD) begin
        if (weQ) mergeQ <= mem[idxQ];
        else     rdataQ <= mem[idxQ];
      end
      validQ <= (nextState == RESP);
      readyQ <= (nextState == IDLE);
    end
  end

  // Array write: only in WR, so each accepted store writes exactly once.
  always_ff @(posedge CLK) begin
    if (state == WR) begin
      mem[idxQ] <= wrWordC;
    end
  end

endmodule
